// File: rtl/dadda_11.sv
// 11x11 unsigned Dadda multiplier: partial-product columns reduced with height limits 9,6,4,3,2.
// Define DADDA_11_PIPE_EN to register the two reduced rows before the final adder (latency 2).
module dadda_11 (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] a,
   input  logic [10:0] b,
   input  logic        valid_in,
   output logic [21:0] y,
   output logic        valid_out
);

   function automatic int stage_limit(input int s);
      case (s)
         0:       return 9;
         1:       return 6;
         2:       return 4;
         3:       return 3;
         4:       return 2;
         default: return 2;
      endcase
   endfunction

   logic [21:0] row0_s;
   logic [21:0] row1_s;
   logic [21:0] sum_s;
   logic        sum_valid_s;
   logic [21:0] y_d;
   logic        valid_out_d;
   logic [21:0] y_q;
   logic        valid_out_q;

   // Column-wise Dadda reduction of the partial-product matrix down to two rows
   always_comb begin : reduce
      logic [15:0] cur  [32];
      logic [15:0] nxt  [32];
      int          cnt  [32];
      int          ncnt [32];
      int          p;
      int          h;
      int          d;
      for (int c = 0; c < 32; c++) begin
         cur[c]  = 16'd0;
         nxt[c]  = 16'd0;
         cnt[c]  = 0;
         ncnt[c] = 0;
      end
      p      = 0;
      h      = 0;
      d      = 0;
      row0_s = 22'd0;
      row1_s = 22'd0;

      for (int i = 0; i < 11; i++) begin
         for (int j = 0; j < 11; j++) begin
            cur[5'(i + j)][4'(cnt[5'(i + j)])] = a[4'(i)] & b[4'(j)];
            cnt[5'(i + j)] = cnt[5'(i + j)] + 1;
         end
      end

      for (int s = 0; s < 5; s++) begin
         d = stage_limit(s);
         for (int c = 0; c < 32; c++) begin
            nxt[c]  = 16'd0;
            ncnt[c] = 0;
         end
         for (int c = 0; c < 22; c++) begin
            p = 0;
            // Carries already landed in ncnt[c]; compress only while the column exceeds d
            for (int k = 0; k < 12; k++) begin
               h = ncnt[5'(c)] + cnt[5'(c)] - p;
               if ((h > d) && (h - d >= 2) && (cnt[5'(c)] - p >= 3)) begin
                  nxt[5'(c)][4'(ncnt[5'(c)])] = cur[5'(c)][4'(p)] ^ cur[5'(c)][4'(p + 1)]
                                              ^ cur[5'(c)][4'(p + 2)];
                  nxt[5'(c + 1)][4'(ncnt[5'(c + 1)])] =
                       (cur[5'(c)][4'(p)] & cur[5'(c)][4'(p + 1)])
                     | (cur[5'(c)][4'(p)] & cur[5'(c)][4'(p + 2)])
                     | (cur[5'(c)][4'(p + 1)] & cur[5'(c)][4'(p + 2)]);
                  ncnt[5'(c)]     = ncnt[5'(c)] + 1;
                  ncnt[5'(c + 1)] = ncnt[5'(c + 1)] + 1;
                  p               = p + 3;
               end else if ((h > d) && (cnt[5'(c)] - p >= 2)) begin
                  nxt[5'(c)][4'(ncnt[5'(c)])] = cur[5'(c)][4'(p)] ^ cur[5'(c)][4'(p + 1)];
                  nxt[5'(c + 1)][4'(ncnt[5'(c + 1)])] = cur[5'(c)][4'(p)] & cur[5'(c)][4'(p + 1)];
                  ncnt[5'(c)]     = ncnt[5'(c)] + 1;
                  ncnt[5'(c + 1)] = ncnt[5'(c + 1)] + 1;
                  p               = p + 2;
               end else begin
                  h = 0;
               end
            end
            for (int k = 0; k < 16; k++) begin
               if ((k >= p) && (k < cnt[5'(c)])) begin
                  nxt[5'(c)][4'(ncnt[5'(c)])] = cur[5'(c)][4'(k)];
                  ncnt[5'(c)] = ncnt[5'(c)] + 1;
               end else begin
                  h = 0;
               end
            end
         end
         for (int c = 0; c < 32; c++) begin
            cur[c] = nxt[c];
            cnt[c] = ncnt[c];
         end
      end

      for (int c = 0; c < 22; c++) begin
         row0_s[5'(c)] = cur[5'(c)][0];
         row1_s[5'(c)] = cur[5'(c)][1];
      end
   end

`ifdef DADDA_11_PIPE_EN
   logic [21:0] row0_q;
   logic [21:0] row1_q;
   logic        row_valid_q;
   logic [21:0] row0_d;
   logic [21:0] row1_d;
   logic        row_valid_d;

   // Next-state for the reduced-row pipeline stage
   always_comb begin
      row0_d      = row0_s;
      row1_d      = row1_s;
      row_valid_d = valid_in;
   end

   // Reduced-row pipeline register, flushed by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         row0_q      <= 22'd0;
         row1_q      <= 22'd0;
         row_valid_q <= 1'b0;
      end else begin
         row0_q      <= row0_d;
         row1_q      <= row1_d;
         row_valid_q <= row_valid_d;
      end
   end

   // Final carry-propagate add on the registered rows
   always_comb begin
      sum_s       = row0_q + row1_q;
      sum_valid_s = row_valid_q;
   end
`else
   // Final carry-propagate add directly on the reduced rows
   always_comb begin
      sum_s       = row0_s + row1_s;
      sum_valid_s = valid_in;
   end
`endif

   // Output next-state: y holds its value on idle cycles
   always_comb begin
      y_d         = y_q;
      valid_out_d = sum_valid_s;
      if (sum_valid_s) begin
         y_d = sum_s;
      end else begin
         y_d = y_q;
      end
   end

   // Output register
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q         <= 22'd0;
         valid_out_q <= 1'b0;
      end else begin
         y_q         <= y_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign y         = y_q;
   assign valid_out = valid_out_q;

endmodule

// File: tb/tb_dadda_11.sv
// Self-checking bench for dadda_11: directed vectors, reset flush and random products via a scoreboard queue.
module tb_dadda_11;

`ifdef DADDA_11_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] a;
   logic [10:0] b;
   logic        valid_in;
   logic [21:0] y;
   logic        valid_out;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [21:0] exp_q [$];
   logic [1:0]  vpipe    = 2'b00;
   logic [21:0] last_y   = 22'd0;

   always #5 clk = ~clk;

   dadda_11 dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .valid_in  (valid_in),
      .y         (y),
      .valid_out (valid_out)
   );

   task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle at the falling edge, update the model at the rising edge, check at the next falling edge
   task automatic step(input logic r, input logic v, input logic [10:0] aa, input logic [10:0] bb,
                       input logic [21:0] ex, input string tag);
      logic exp_v;
      rst      = r;
      valid_in = v;
      a        = aa;
      b        = bb;
      @(posedge clk);
      if (r) begin
         exp_q.delete();
         vpipe  = 2'b00;
         last_y = 22'd0;
      end else begin
         if (v) exp_q.push_back(ex);
         vpipe = {vpipe[0], v};
      end
      @(negedge clk);
      exp_v = vpipe[LAT-1];
      check({tag, "_valid"}, {21'd0, valid_out}, {21'd0, exp_v});
      if (exp_v && (exp_q.size() > 0)) last_y = exp_q.pop_front();
      check({tag, "_y"}, y, last_y);
   endtask

   initial begin
      logic [10:0] ra;
      logic [10:0] rb;
      logic        rv;
      rst      = 1'b1;
      valid_in = 1'b0;
      a        = 11'd0;
      b        = 11'd0;
      @(negedge clk);
      step(1'b1, 1'b1, 11'd5, 11'd6, 22'd30, "reset0");
      step(1'b1, 1'b0, 11'd0, 11'd0, 22'd0, "reset1");

      step(1'b0, 1'b1, 11'd987, 11'd135, 22'd133245, "b2b_0");
      step(1'b0, 1'b1, 11'd771, 11'd681, 22'd525051, "b2b_1");
      step(1'b0, 1'b1, 11'd7, 11'd3, 22'd21, "b2b_2");
      step(1'b0, 1'b0, 11'd100, 11'd100, 22'd10000, "idle0");
      step(1'b0, 1'b0, 11'd9, 11'd9, 22'd81, "idle1");
      step(1'b0, 1'b0, 11'd0, 11'd0, 22'd0, "idle2");

      step(1'b0, 1'b1, 11'd2047, 11'd2047, 22'd4190209, "max");
      step(1'b0, 1'b1, 11'd0, 11'd2047, 22'd0, "zero");
      step(1'b0, 1'b1, 11'd1, 11'd1234, 22'd1234, "one");
      step(1'b0, 1'b0, 11'd0, 11'd0, 22'd0, "drain0");
      step(1'b0, 1'b0, 11'd0, 11'd0, 22'd0, "drain1");

      step(1'b0, 1'b1, 11'd1000, 11'd2000, 22'd2000000, "flight");
      step(1'b1, 1'b1, 11'd1500, 11'd1500, 22'd2250000, "flush");
      step(1'b0, 1'b0, 11'd0, 11'd0, 22'd0, "post0");
      step(1'b0, 1'b0, 11'd0, 11'd0, 22'd0, "post1");
      step(1'b0, 1'b1, 11'd1024, 11'd1024, 22'd1048576, "post2");
      step(1'b0, 1'b0, 11'd0, 11'd0, 22'd0, "post3");
      step(1'b0, 1'b0, 11'd0, 11'd0, 22'd0, "post4");

      for (int i = 0; i < 10000; i++) begin
         ra = 11'($urandom_range(0, 2047));
         rb = 11'($urandom_range(0, 2047));
         rv = ($urandom_range(0, 7) != 0);
         step(1'b0, rv, ra, rb, {11'd0, ra} * {11'd0, rb}, "rand");
      end
      step(1'b0, 1'b0, 11'd0, 11'd0, 22'd0, "end0");
      step(1'b0, 1'b0, 11'd0, 11'd0, 22'd0, "end1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
